// File: rtl/i2c_slave_pkg.sv
// Shared types and bus constants for the I2C register-interface target.
package i2c_slave_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK
  } i2c_slv_state_t;

  localparam logic       I2C_ACK        = 1'b0;
  localparam logic       I2C_NACK       = 1'b1;
  localparam logic [6:0] I2C_GCALL_ADDR = 7'h00;

endpackage

// File: rtl/i2c_slave_filter.sv
// Pad conditioner: 2-flop synchronizer, stability filter and edge pulses.
module i2c_slave_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall
);

  logic       sync_p0;
  logic       sync_p1;
  logic [3:0] cnt;

  // Idle I2C lines are high, so everything resets to the released level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      cnt     <= 4'd0;
      level   <= 1'b1;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      sync_p0 <= pad;
      sync_p1 <= sync_p0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      if (sync_p1 != level) begin
        if (cnt == 4'(FILTER_LEN - 1)) begin
          level <= sync_p1;
          rise  <= sync_p1;
          fall  <= ~sync_p1;
          cnt   <= 4'd0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end else begin
        cnt <= 4'd0;
      end
    end
  end

endmodule

// File: rtl/i2c_slave_regif.sv
// I2C target translating bus transfers into single-cycle register port accesses.
module i2c_slave_regif
  import i2c_slave_pkg::*;
#(
  parameter int FILTER_LEN = 3,
  parameter bit AUTO_INC   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] slave_addr_i,
  input  logic       scl_pad_i,
  input  logic       sda_pad_i,
  output logic       sda_pad_o,
  output logic       sda_padoen_o,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  output logic       reg_we_o,
  output logic       reg_re_o,
  input  logic [7:0] reg_rdata_i,
  output logic       busy_o
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_slave_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk   (clk),
    .rst   (rst),
    .pad   (scl_pad_i),
    .level (scl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_slave_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk   (clk),
    .rst   (rst),
    .pad   (sda_pad_i),
    .level (sda),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  assign start_det = sda_fall & scl;
  assign stop_det  = sda_rise & scl;
  assign sda_pad_o = 1'b0;

  i2c_slv_state_t state;
  logic [3:0]     bit_cnt;
  logic [7:0]     shreg;
  logic [7:0]     byte_in;
  logic           rw;
  logic           load_pend;

  assign byte_in = {shreg[6:0], sda};

  // In the ACK states bit_cnt marks whether the 9th rising edge has been seen,
  // separating the falling edge that starts the ACK from the one that ends it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= 4'd0;
      rw           <= 1'b0;
      load_pend    <= 1'b0;
      sda_padoen_o <= 1'b1;
      busy_o       <= 1'b0;
      reg_addr_o   <= 8'h00;
      reg_wdata_o  <= 8'h00;
      reg_we_o     <= 1'b0;
      reg_re_o     <= 1'b0;
    end else begin
      reg_we_o  <= 1'b0;
      reg_re_o  <= 1'b0;
      load_pend <= reg_re_o;
      if (load_pend)
        shreg <= reg_rdata_i;
      if (AUTO_INC && (reg_we_o || reg_re_o))
        reg_addr_o <= reg_addr_o + 8'd1;

      if (stop_det) begin
        state        <= IDLE;
        busy_o       <= 1'b0;
        sda_padoen_o <= 1'b1;
        bit_cnt      <= 4'd0;
      end else if (start_det) begin
        state        <= ADDR;
        sda_padoen_o <= 1'b1;
        bit_cnt      <= 4'd0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shreg   <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                if (byte_in[7:1] == slave_addr_i && byte_in[7:1] != I2C_GCALL_ADDR) begin
                  state  <= ADDR_ACK;
                  rw     <= byte_in[0];
                  busy_o <= 1'b1;
                end else begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
                end
              end
            end
          end
          ADDR_ACK: begin
            if (scl_rise) begin
              bit_cnt <= 4'd1;
              if (rw)
                reg_re_o <= 1'b1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd0) begin
                sda_padoen_o <= I2C_ACK;
              end else begin
                bit_cnt <= 4'd0;
                if (rw) begin
                  sda_padoen_o <= shreg[7];
                  state        <= RD_DATA;
                end else begin
                  sda_padoen_o <= 1'b1;
                  state        <= PTR;
                end
              end
            end
          end
          PTR, WR_DATA: begin
            if (scl_rise) begin
              shreg   <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                state   <= WR_ACK;
                if (state == PTR) begin
                  reg_addr_o <= byte_in;
                end else begin
                  reg_wdata_o <= byte_in;
                  reg_we_o    <= 1'b1;
                end
              end
            end
          end
          WR_ACK: begin
            if (scl_rise) begin
              bit_cnt <= 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd0) begin
                sda_padoen_o <= I2C_ACK;
              end else begin
                bit_cnt      <= 4'd0;
                sda_padoen_o <= 1'b1;
                state        <= WR_DATA;
              end
            end
          end
          RD_DATA: begin
            if (scl_rise) begin
              shreg   <= {shreg[6:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_padoen_o <= 1'b1;
                bit_cnt      <= 4'd0;
                state        <= RD_ACK;
              end else begin
                sda_padoen_o <= shreg[7];
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (sda == I2C_NACK) begin
                state  <= IDLE;
                busy_o <= 1'b0;
              end else begin
                bit_cnt  <= 4'd1;
                reg_re_o <= 1'b1;
              end
            end else if (scl_fall && bit_cnt == 4'd1) begin
              bit_cnt      <= 4'd0;
              sda_padoen_o <= shreg[7];
              state        <= RD_DATA;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
